// File: rtl/seq_mult_nbit.sv
// seq_mult_nbit
//   Sequential shift-add multiplier. Forms a WIDTH x WIDTH -> 2*WIDTH product,
//   unsigned or two's-complement signed, with one add+shift per clock.
//   start is accepted in IDLE or DONE. busy is high while iterating. done
//   pulses for one cycle when p is valid.
//
// Ports
//   clk          in   1         rising-edge clock
//   reset        in   1         asynchronous, active-high
//   start        in   1         operation request (IDLE/DONE only)
//   signed_mode  in   1         1 = two's-complement operands, latched with start
//   a            in   WIDTH     multiplier, latched with start
//   b            in   WIDTH     multiplicand, latched with start
//   busy         out  1         high while the FSM is in RUN
//   done         out  1         one-cycle pulse, p valid
//   p            out  2*WIDTH   product, held until the next done
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one add+shift iteration per edge, counter counts down to 0
// DONE  | p valid for this cycle; start here chains straight into RUN

module seq_mult_nbit #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH:0]     acc_q, acc_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sgn_q, sgn_d;
  logic [2*WIDTH-1:0] p_q, p_d;

  // One iteration of the datapath. The sum is carried in WIDTH+2 bits so the
  // bit shifted into the accumulator MSB is the true carry (unsigned) or the
  // true sign (signed) of the WIDTH+1-bit add.
  logic               last;
  logic [WIDTH+1:0]   acc_ext;
  logic [WIDTH+1:0]   add_ext;
  logic [WIDTH+1:0]   sum;
  logic [WIDTH:0]     acc_nxt;
  logic [WIDTH-1:0]   q_nxt;

  always_comb begin
    last    = (cnt_q == '0);
    acc_ext = {sgn_q & acc_q[WIDTH], acc_q};
    add_ext = q_q[0] ? {{2{sgn_q & b_q[WIDTH-1]}}, b_q} : '0;
    // In signed mode the multiplier MSB carries weight -2^(WIDTH-1), so the
    // final partial product is subtracted instead of added.
    if (sgn_q && last) sum = acc_ext - add_ext;
    else               sum = acc_ext + add_ext;
    acc_nxt = sum[WIDTH+1:1];
    q_nxt   = {sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    q_d     = q_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    p_d     = p_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          q_d     = a;
          b_d     = b;
          sgn_d   = signed_mode;
          acc_d   = '0;
          cnt_d   = CNT_LOAD;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_nxt;
        q_d   = q_nxt;
        if (last) begin
          p_d     = {acc_nxt[WIDTH-1:0], q_nxt};
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      p_q     <= p_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign p    = p_q;

endmodule

// File: tb/tb_seq_mult_nbit.sv
// tb_seq_mult_nbit
//   Directed checks of seq_mult_nbit at WIDTH=4 and WIDTH=8 against
//   hand-computed products and handshake timing.

module tb_seq_mult_nbit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        signed_mode;
  logic [3:0]  a;
  logic [3:0]  b;
  logic        busy;
  logic        done;
  logic [7:0]  p;

  logic        start8;
  logic        signed_mode8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic [15:0] p8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_mult_nbit #(.WIDTH(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .p           (p)
  );

  seq_mult_nbit #(.WIDTH(8)) dut8 (
    .clk         (clk),
    .reset       (reset),
    .start       (start8),
    .signed_mode (signed_mode8),
    .a           (a8),
    .b           (b8),
    .busy        (busy8),
    .done        (done8),
    .p           (p8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Start one WIDTH=4 operation, scramble the operand inputs while it runs,
  // and check busy, latency (done in 5th cycle after accept) and product.
  task automatic do_op(input logic [3:0] ai, input logic [3:0] bi, input logic si,
                       input logic [7:0] ep, input string tag);
    int n;
    @(negedge clk);
    start = 1'b1; a = ai; b = bi; signed_mode = si;
    @(negedge clk);
    start = 1'b0; a = ~ai; b = ~bi; signed_mode = ~si;
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      chk({tag, "_busy"}, busy, 1);
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 5);
    chk({tag, "_p"}, p, ep);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic do_op8(input logic [7:0] ai, input logic [7:0] bi, input logic si,
                        input logic [15:0] ep, input string tag);
    int n;
    @(negedge clk);
    start8 = 1'b1; a8 = ai; b8 = bi; signed_mode8 = si;
    @(negedge clk);
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    n = 1;
    while (done8 !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, n, 9);
    chk({tag, "_p"}, p8, ep);
  endtask

  logic [3:0] ca [4];
  logic [3:0] cb [4];
  logic       cs [4];
  logic [7:0] cp [4];

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    start8 = 1'b0; signed_mode8 = 1'b0; a8 = '0; b8 = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_p", p, 0);
    @(negedge clk);
    reset = 1'b0;

    // unsigned corner
    do_op(4'd15, 4'd15, 1'b0, 8'hE1, "u15x15");
    // signed cases
    do_op(4'h8, 4'h8, 1'b1, 8'h40, "s_m8xm8");
    do_op(4'h8, 4'h7, 1'b1, 8'hC8, "s_m8x7");
    do_op(4'h3, 4'hF, 1'b1, 8'hFD, "s_3xm1");
    // zero / identity
    do_op(4'd0, 4'd9, 1'b0, 8'h00, "u0x9");
    do_op(4'd1, 4'd9, 1'b0, 8'h09, "u1x9");
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_p", p, 8'h09);
      chk("hold_done", done, 0);
    end

    // start held high continuously: one product every 5 cycles
    ca[0] = 4'd7;  cb[0] = 4'd6;  cs[0] = 1'b0; cp[0] = 8'h2A;
    ca[1] = 4'hD;  cb[1] = 4'h5;  cs[1] = 1'b1; cp[1] = 8'hF1;
    ca[2] = 4'd12; cb[2] = 4'd11; cs[2] = 1'b0; cp[2] = 8'h84;
    ca[3] = 4'h7;  cb[3] = 4'h8;  cs[3] = 1'b1; cp[3] = 8'hC8;
    @(negedge clk);
    start = 1'b1; a = ca[0]; b = cb[0]; signed_mode = cs[0];
    for (int j = 0; j < 4; j++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (done !== 1'b1) begin
          a = 4'($urandom); b = 4'($urandom); signed_mode = 1'($urandom);
        end
      end while (done !== 1'b1 && n < 20);
      chk("b2b_period", n, 5);
      chk("b2b_p", p, cp[j]);
      if (j < 3) begin
        a = ca[j+1]; b = cb[j+1]; signed_mode = cs[j+1];
      end else begin
        start = 1'b0;
      end
    end

    // asynchronous reset on the 2nd RUN cycle aborts the operation
    @(negedge clk);
    start = 1'b1; a = 4'd9; b = 4'd9; signed_mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("abort_busy1", busy, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_p", p, 0);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done === 1'b1) n++;
    end
    chk("abort_no_done", n, 0);
    do_op(4'd5, 4'd6, 1'b0, 8'h1E, "u5x6");

    // WIDTH=8 instance
    do_op8(8'hFF, 8'hFF, 1'b0, 16'hFE01, "w8_u255x255");
    do_op8(8'h80, 8'h80, 1'b1, 16'h4000, "w8_s_m128xm128");
    do_op8(8'hFD, 8'd100, 1'b1, 16'hFED4, "w8_s_m3x100");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
